// File: rtl/pipeline_id_hazard_stage.sv
// pipeline_id_hazard_stage: decode stage with register file, load-use stall FSM and ID/EX register
module pipeline_id_hazard_stage #(
   parameter int DATA_W = 32,
   parameter int NREG = 32,
   parameter int CTRL_W = 16,
   parameter int LOAD_STALL = 1,
   localparam int AW = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [AW-1:0]     id_rs,
   input  logic [AW-1:0]     id_rt,
   input  logic [AW-1:0]     id_dst,
   input  logic              id_regwr,
   input  logic              id_memrd,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              wb_wr,
   input  logic [AW-1:0]     wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ex_flush,
   output logic              stall_out,
   output logic              ex_valid,
   output logic [AW-1:0]     ex_rs,
   output logic [AW-1:0]     ex_rt,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [AW-1:0]     ex_dst,
   output logic              ex_regwr,
   output logic              ex_memrd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [DATA_W-1:0] ex_imm
);
   typedef enum logic {RUN, STALL} state_t;
   localparam logic [1:0] CNT_INIT = 2'(LOAD_STALL > 1 ? LOAD_STALL - 2 : 0);
   logic [DATA_W-1:0] rf [NREG];
   logic [DATA_W-1:0] rd_a, rd_b;
   logic [1:0] cnt;
   state_t state;
   logic haz, bubble;
   // register file: reg 0 never written
   always_ff @(posedge clk or negedge reset)
      if (!reset) for (int i = 0; i < NREG; i++) rf[i] <= '0;
      else if (wb_wr && wb_addr != '0) rf[wb_addr] <= wb_data;
   // operand reads with same-cycle write-back bypass
   always_comb begin
      rd_a = (id_rs == '0) ? '0 : (wb_wr && wb_addr == id_rs) ? wb_data : rf[id_rs];
      rd_b = (id_rt == '0) ? '0 : (wb_wr && wb_addr == id_rt) ? wb_data : rf[id_rt];
   end
   // load-use detection and stall/bubble decisions; flush overrides any stall
   always_comb begin
      haz = id_valid && ex_valid && ex_memrd && ex_regwr && ex_dst != '0 &&
            (ex_dst == id_rs || ex_dst == id_rt);
      stall_out = ex_flush ? 1'b0 : (state == STALL) ? 1'b1 : haz;
      bubble = ex_flush || state == STALL || haz;
   end
   // stall FSM: extra bubbles beyond the first are counted down in STALL
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= RUN;
         cnt <= '0;
      end else if (ex_flush) state <= RUN;
      else if (state == STALL) begin
         if (cnt == '0) state <= RUN;
         else cnt <= cnt - 2'd1;
      end else if (haz && LOAD_STALL > 1) begin
         state <= STALL;
         cnt <= CNT_INIT;
      end
   // ID/EX register: a bubble clears the control fields and holds the data fields
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         ex_valid <= 1'b0;
         ex_rs <= '0;
         ex_rt <= '0;
         ex_a <= '0;
         ex_b <= '0;
         ex_dst <= '0;
         ex_regwr <= 1'b0;
         ex_memrd <= 1'b0;
         ex_ctrl <= '0;
         ex_imm <= '0;
      end else if (bubble) begin
         ex_valid <= 1'b0;
         ex_regwr <= 1'b0;
         ex_memrd <= 1'b0;
         ex_ctrl <= '0;
      end else begin
         ex_valid <= id_valid;
         ex_rs <= id_rs;
         ex_rt <= id_rt;
         ex_a <= rd_a;
         ex_b <= rd_b;
         ex_dst <= id_dst;
         ex_regwr <= id_regwr;
         ex_memrd <= id_memrd;
         ex_ctrl <= id_ctrl;
         ex_imm <= id_imm;
      end
endmodule
